hazard_ctrl: RTL and testbench

// Parametrised pipeline hazard controller for the 5-stage core; successor to the combinational stall detector.

---
 rtl/hazard_pkg.sv | 40 ++++
 rtl/hazard_sb_stage.sv | 29 ++
 rtl/hazard_ctrl.sv | 162 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the hazard controller: shadow-entry layout, stage indices, halt FSM states.
// No logic of its own; zero latency.
// No flow control; consumed by hazard_ctrl and hazard_sb_stage.
package hazard_pkg;

   // Default register-index width (8 architectural registers).
   localparam int REG_W_DEF = 3;
   // Shadow entries carry destinations at this fixed width; hazard_ctrl zero-extends into it.
   localparam int REG_W_MAX = 8;

   localparam int STAGE_X  = 0;
   localparam int STAGE_M  = 1;
   localparam int STAGE_W  = 2;
   localparam int N_STAGES = 3;

   // One in-flight instruction as seen by the hazard logic.
   typedef struct packed {
      logic                 v;   // real instruction (not a bubble)
      logic [REG_W_MAX-1:0] rd;  // destination register
      logic                 rw;  // writes rd
      logic                 ld;  // is a load
   } sb_entry_t;

   localparam sb_entry_t SB_BUBBLE = '0;

   typedef enum logic [1:0] {
      HS_RUN    = 2'd0,
      HS_DRAIN  = 2'd1,
      HS_HALTED = 2'd2
   } halt_st_t;

   // A stage produces a RAW hazard on a source only if it really writes that register.
   function automatic logic sb_match(input sb_entry_t            e,
                                     input logic [REG_W_MAX-1:0] src,
                                     input logic                 used,
                                     input logic                 r0_zero);
      return e.v & e.rw & used & (e.rd == src) & ~(r0_zero & (src == '0));
   endfunction

endpackage

// File: rtl/hazard_sb_stage.sv
// One shadow-scoreboard entry tracking the instruction held in a pipeline stage.
// Registered: the entry presented on i_dat appears on o_dat one cycle later.
// No backpressure; when i_load is low the stage fills with a bubble.
module hazard_sb_stage
   import hazard_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      i_load,
   input  sb_entry_t i_dat,
   output sb_entry_t o_dat
);

   sb_entry_t r_ent;

   // Advance every cycle: take the upstream entry when loading, otherwise become a bubble.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ent <= SB_BUBBLE;
      end else if (i_load) begin
         r_ent <= i_dat;
      end else begin
         r_ent <= SB_BUBBLE;
      end
   end

   assign o_dat = r_ent;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: shadow X/M/W scoreboard, RAW stall, branch flush, halt drain, stall counter.
// Outputs are combinational from current state and decode inputs (zero latency); state moves on clk.
// Stalls hold PC/IF-ID and inject an ID/EX bubble; a taken branch flushes and overrides any stall.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_W     = REG_W_DEF,  // must not exceed REG_W_MAX
   parameter int FWD_EN    = 1,
   parameter int RF_BYPASS = 1,
   parameter int R0_ZERO   = 0,
   parameter int CNT_W     = 16
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             dec_valid,
   input  logic [REG_W-1:0] dec_rs,
   input  logic [REG_W-1:0] dec_rt,
   input  logic             dec_rs_used,
   input  logic             dec_rt_used,
   input  logic [REG_W-1:0] dec_rd,
   input  logic             dec_regwrite,
   input  logic             dec_memread,
   input  logic             br_taken,
   input  logic             halt_req,
   output logic             stall_fd,
   output logic             nop_de,
   output logic             flush_fd,
   output logic             flush_de,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt
);

   sb_entry_t            w_dec_ent;
   sb_entry_t            w_ent [N_STAGES];
   logic [REG_W_MAX-1:0] w_rs;
   logic [REG_W_MAX-1:0] w_rt;
   logic [N_STAGES-1:0]  w_hz;
   logic                 w_raw;
   logic                 w_stall;
   logic                 w_x_load;
   logic                 w_empty;
   logic                 w_halt_pend;
   logic                 w_halted;
   halt_st_t             r_hstate;
   halt_st_t             w_hstate_nxt;
   logic [CNT_W-1:0]     r_stall_cnt;

   assign w_rs = REG_W_MAX'(dec_rs);
   assign w_rt = REG_W_MAX'(dec_rt);

   // Describe the decode-stage instruction as a shadow entry ready to enter X.
   always_comb begin
      w_dec_ent    = SB_BUBBLE;
      w_dec_ent.v  = 1'b1;
      w_dec_ent.rd = REG_W_MAX'(dec_rd);
      w_dec_ent.rw = dec_regwrite;
      w_dec_ent.ld = dec_memread;
   end

   // X only admits a decode op that is really leaving decode this cycle.
   assign w_x_load = dec_valid & ~stall_fd & ~flush_de & ~w_halt_pend;

   hazard_sb_stage u_sb_x (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_x_load),
      .i_dat  (w_dec_ent),
      .o_dat  (w_ent[STAGE_X])
   );

   hazard_sb_stage u_sb_m (
      .clk    (clk),
      .rst    (rst),
      .i_load (1'b1),
      .i_dat  (w_ent[STAGE_X]),
      .o_dat  (w_ent[STAGE_M])
   );

   hazard_sb_stage u_sb_w (
      .clk    (clk),
      .rst    (rst),
      .i_load (1'b1),
      .i_dat  (w_ent[STAGE_M]),
      .o_dat  (w_ent[STAGE_W])
   );

   // Per-stage RAW match against either decode source.
   always_comb begin
      w_hz = '0;
      for (int s = 0; s < N_STAGES; s++) begin
         w_hz[s] = sb_match(w_ent[s], w_rs, dec_rs_used, R0_ZERO != 0)
                 | sb_match(w_ent[s], w_rt, dec_rt_used, R0_ZERO != 0);
      end
   end

   // With forwarding only a load in X cannot be bypassed; without it every producer still in flight blocks.
   always_comb begin
      w_raw = 1'b0;
      if (FWD_EN != 0) begin
         w_raw = w_hz[STAGE_X] & w_ent[STAGE_X].ld;
      end else begin
         w_raw = w_hz[STAGE_X] | w_hz[STAGE_M] | ((RF_BYPASS == 0) & w_hz[STAGE_W]);
      end
   end

   // A squashed decode op never stalls.
   assign w_stall = dec_valid & w_raw & ~br_taken;
   assign w_empty = ~(w_ent[STAGE_X].v | w_ent[STAGE_M].v | w_ent[STAGE_W].v);

   // Halt FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hstate <= HS_RUN;
      end else begin
         r_hstate <= w_hstate_nxt;
      end
   end

   // Halt FSM next state: halt op must actually issue, then drain until X/M/W are empty.
   always_comb begin
      w_hstate_nxt = r_hstate;
      w_halt_pend  = 1'b0;
      w_halted     = 1'b0;
      case (r_hstate)
         HS_RUN: begin
            if (halt_req & dec_valid & ~br_taken & ~w_stall) begin
               w_hstate_nxt = HS_DRAIN;
            end
         end
         HS_DRAIN: begin
            w_halt_pend = 1'b1;
            if (w_empty) begin
               w_hstate_nxt = HS_HALTED;
            end
         end
         HS_HALTED: begin
            w_halt_pend = 1'b1;
            w_halted    = 1'b1;
         end
         default: begin
            w_hstate_nxt = HS_RUN;
         end
      endcase
   end

   // Count genuine RAW stall cycles, ignoring halt freeze, saturating at all-ones.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_cnt <= '0;
      end else if (w_stall & ~w_halt_pend & (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   assign stall_fd  = w_stall | w_halt_pend;
   assign nop_de    = w_stall | w_halt_pend;
   assign flush_fd  = br_taken;
   assign flush_de  = br_taken;
   assign halted    = w_halted;
   assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl across forwarding, no-forwarding and saturating configurations.
// Expected outputs are queued per cycle by the stimulus and compared by a separate monitor.
// Three instances share clock and reset; only the instance under test sees a non-idle decode slot.
`timescale 1ns/1ps
module tb_hazard_ctrl;

   typedef struct packed {
      logic       v;
      logic [2:0] rs;
      logic [2:0] rt;
      logic       rsu;
      logic       rtu;
      logic [2:0] rd;
      logic       rw;
      logic       ld;
      logic       br;
      logic       halt;
   } stim_t;

   typedef struct packed {
      logic        stall;
      logic        nop;
      logic        ffd;
      logic        fde;
      logic        halted;
      logic [15:0] cnt;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rst_next = 1'b0;
   stim_t       s [3];
   logic [2:0]  o_stall;
   logic [2:0]  o_nop;
   logic [2:0]  o_ffd;
   logic [2:0]  o_fde;
   logic [2:0]  o_halted;
   logic [15:0] cnt_a;
   logic [15:0] cnt_b;
   logic [1:0]  cnt_c;

   obs_t  exp_q  [$];
   int    inst_q [$];
   string name_q [$];
   int    checks = 0;
   int    errors = 0;

   obs_t  m_e;
   obs_t  m_a;
   int    m_i;
   string m_nm;

   always #5 clk = ~clk;

   // A: forwarding, r0 hardwired
   hazard_ctrl #(.REG_W(3), .FWD_EN(1), .RF_BYPASS(1), .R0_ZERO(1), .CNT_W(16)) u_a (
      .clk(clk), .rst(rst), .dec_valid(s[0].v), .dec_rs(s[0].rs), .dec_rt(s[0].rt),
      .dec_rs_used(s[0].rsu), .dec_rt_used(s[0].rtu), .dec_rd(s[0].rd),
      .dec_regwrite(s[0].rw), .dec_memread(s[0].ld), .br_taken(s[0].br), .halt_req(s[0].halt),
      .stall_fd(o_stall[0]), .nop_de(o_nop[0]), .flush_fd(o_ffd[0]), .flush_de(o_fde[0]),
      .halted(o_halted[0]), .stall_cnt(cnt_a));

   // B: no forwarding, regfile bypass
   hazard_ctrl #(.REG_W(3), .FWD_EN(0), .RF_BYPASS(1), .R0_ZERO(0), .CNT_W(16)) u_b (
      .clk(clk), .rst(rst), .dec_valid(s[1].v), .dec_rs(s[1].rs), .dec_rt(s[1].rt),
      .dec_rs_used(s[1].rsu), .dec_rt_used(s[1].rtu), .dec_rd(s[1].rd),
      .dec_regwrite(s[1].rw), .dec_memread(s[1].ld), .br_taken(s[1].br), .halt_req(s[1].halt),
      .stall_fd(o_stall[1]), .nop_de(o_nop[1]), .flush_fd(o_ffd[1]), .flush_de(o_fde[1]),
      .halted(o_halted[1]), .stall_cnt(cnt_b));

   // C: no forwarding, no bypass, 2-bit counter
   hazard_ctrl #(.REG_W(3), .FWD_EN(0), .RF_BYPASS(0), .R0_ZERO(0), .CNT_W(2)) u_c (
      .clk(clk), .rst(rst), .dec_valid(s[2].v), .dec_rs(s[2].rs), .dec_rt(s[2].rt),
      .dec_rs_used(s[2].rsu), .dec_rt_used(s[2].rtu), .dec_rd(s[2].rd),
      .dec_regwrite(s[2].rw), .dec_memread(s[2].ld), .br_taken(s[2].br), .halt_req(s[2].halt),
      .stall_fd(o_stall[2]), .nop_de(o_nop[2]), .flush_fd(o_ffd[2]), .flush_de(o_fde[2]),
      .halted(o_halted[2]), .stall_cnt(cnt_c));

   function automatic stim_t mk(input logic v, input logic [2:0] rs, input logic [2:0] rt,
                                input logic rsu, input logic rtu, input logic [2:0] rd,
                                input logic rw, input logic ld, input logic br, input logic halt);
      stim_t t;
      t.v = v; t.rs = rs; t.rt = rt; t.rsu = rsu; t.rtu = rtu;
      t.rd = rd; t.rw = rw; t.ld = ld; t.br = br; t.halt = halt;
      return t;
   endfunction

   function automatic obs_t ex(input logic st, input logic fl, input logic h, input int c);
      obs_t o;
      o.stall = st; o.nop = st; o.ffd = fl; o.fde = fl; o.halted = h; o.cnt = 16'(c);
      return o;
   endfunction

   function automatic obs_t get_obs(input int i);
      obs_t o;
      o.stall  = o_stall[i];
      o.nop    = o_nop[i];
      o.ffd    = o_ffd[i];
      o.fde    = o_fde[i];
      o.halted = o_halted[i];
      case (i)
         0:       o.cnt = cnt_a;
         1:       o.cnt = cnt_b;
         default: o.cnt = {14'd0, cnt_c};
      endcase
      return o;
   endfunction

   // Drive one cycle of decode inputs on instance i and queue the outputs expected in that cycle.
   task automatic step(input int i, input stim_t st, input obs_t e, input string nm);
      @(posedge clk);
      #1;
      rst = rst_next;
      for (int k = 0; k < 3; k++) s[k] = '0;
      s[i] = st;
      exp_q.push_back(e);
      inst_q.push_back(i);
      name_q.push_back(nm);
   endtask

   // Monitor: compare the observed outputs against the oldest queued expectation each cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         m_e  = exp_q.pop_front();
         m_i  = inst_q.pop_front();
         m_nm = name_q.pop_front();
         m_a  = get_obs(m_i);
         checks++;
         if (m_a !== m_e) begin
            errors++;
            $display("FAIL %s inst%0d: got stall=%b nop=%b flush_fd=%b flush_de=%b halted=%b cnt=%0d, want stall=%b nop=%b flush_fd=%b flush_de=%b halted=%b cnt=%0d",
                     m_nm, m_i, m_a.stall, m_a.nop, m_a.ffd, m_a.fde, m_a.halted, m_a.cnt,
                     m_e.stall, m_e.nop, m_e.ffd, m_e.fde, m_e.halted, m_e.cnt);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "timeout");
   end

   initial begin
      for (int k = 0; k < 3; k++) s[k] = '0;

      // Reset state on every instance
      step(0, '0, ex(0, 0, 0, 0), "reset_a");
      step(1, '0, ex(0, 0, 0, 0), "reset_b");
      step(2, '0, ex(0, 0, 0, 0), "reset_c");
      rst_next = 1'b1;
      step(0, '0, ex(0, 0, 0, 0), "post_reset");

      // A: load-use, unused source, r0, branch flush
      step(0, mk(1, 0, 0, 0, 0, 3, 1, 1, 0, 0), ex(0, 0, 0, 0), "lu_load");
      step(0, mk(1, 3, 2, 1, 1, 1, 1, 0, 0, 0), ex(1, 0, 0, 0), "lu_stall");
      step(0, mk(1, 3, 2, 1, 1, 1, 1, 0, 0, 0), ex(0, 0, 0, 1), "lu_release");
      step(0, mk(1, 0, 0, 0, 0, 3, 1, 1, 0, 0), ex(0, 0, 0, 1), "ld_again");
      step(0, mk(1, 2, 3, 1, 0, 5, 1, 0, 0, 0), ex(0, 0, 0, 1), "unused_rt");
      step(0, mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0), ex(0, 0, 0, 1), "ld_r0");
      step(0, mk(1, 0, 0, 1, 1, 6, 1, 0, 0, 0), ex(0, 0, 0, 1), "r0_use");
      step(0, mk(1, 0, 0, 0, 0, 3, 1, 1, 0, 0), ex(0, 0, 0, 1), "br_ld");
      step(0, mk(1, 3, 0, 1, 0, 5, 1, 1, 1, 0), ex(0, 1, 0, 1), "br_flush");
      step(0, mk(1, 5, 0, 1, 0, 7, 1, 0, 0, 0), ex(0, 0, 0, 1), "br_bubble");
      step(0, '0, ex(0, 0, 0, 1), "a_idle");

      // B: no forwarding with regfile bypass, unqualified writer, unused source
      step(1, mk(1, 0, 0, 0, 0, 2, 1, 0, 0, 0), ex(0, 0, 0, 0), "nf1_add");
      step(1, mk(1, 2, 5, 1, 1, 4, 1, 0, 0, 0), ex(1, 0, 0, 0), "nf1_x");
      step(1, mk(1, 2, 5, 1, 1, 4, 1, 0, 0, 0), ex(1, 0, 0, 1), "nf1_m");
      step(1, mk(1, 2, 5, 1, 1, 4, 1, 0, 0, 0), ex(0, 0, 0, 2), "nf1_bypass");
      step(1, '0, ex(0, 0, 0, 2), "b_idle");
      step(1, mk(1, 0, 0, 0, 0, 3, 0, 0, 0, 0), ex(0, 0, 0, 2), "st_norw");
      step(1, mk(1, 3, 0, 1, 0, 6, 1, 0, 0, 0), ex(0, 0, 0, 2), "st_read");
      step(1, mk(1, 7, 6, 1, 0, 1, 1, 0, 0, 0), ex(0, 0, 0, 2), "unused_rt_nf");
      step(1, '0, ex(0, 0, 0, 2), "b_idle2");

      // C: no forwarding, no bypass, counter saturation at 3
      step(2, mk(1, 0, 0, 0, 0, 2, 1, 0, 0, 0), ex(0, 0, 0, 0), "nf0_add");
      step(2, mk(1, 2, 5, 1, 1, 4, 1, 0, 0, 0), ex(1, 0, 0, 0), "nf0_x");
      step(2, mk(1, 2, 5, 1, 1, 4, 1, 0, 0, 0), ex(1, 0, 0, 1), "nf0_m");
      step(2, mk(1, 2, 5, 1, 1, 4, 1, 0, 0, 0), ex(1, 0, 0, 2), "nf0_w");
      step(2, mk(1, 2, 5, 1, 1, 4, 1, 0, 0, 0), ex(0, 0, 0, 3), "nf0_go");
      step(2, mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0), ex(0, 0, 0, 3), "nf0_indep");
      step(2, mk(1, 4, 0, 1, 0, 1, 1, 0, 0, 0), ex(1, 0, 0, 3), "sat_m");
      step(2, mk(1, 4, 0, 1, 0, 1, 1, 0, 0, 0), ex(1, 0, 0, 3), "sat_w");
      step(2, mk(1, 4, 0, 1, 0, 1, 1, 0, 0, 0), ex(0, 0, 0, 3), "sat_hold");
      step(2, '0, ex(0, 0, 0, 3), "c_idle");

      // A: halt with two ops in flight, drain, sticky halted
      step(0, mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0), ex(0, 0, 0, 1), "h_op1");
      step(0, mk(1, 0, 0, 0, 0, 2, 1, 0, 0, 0), ex(0, 0, 0, 1), "h_op2");
      step(0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1), ex(0, 0, 0, 1), "h_req");
      for (int k = 0; k < 4; k++)
         step(0, mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0), ex(1, 0, 0, 1), "h_drain");
      step(0, mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0), ex(1, 0, 1, 1), "h_halted");
      step(0, '0, ex(1, 0, 1, 1), "h_sticky");

      // C: reset asserted in the middle of a stall
      step(2, mk(1, 0, 0, 0, 0, 2, 1, 0, 0, 0), ex(0, 0, 0, 3), "rs_add");
      step(2, mk(1, 2, 0, 1, 0, 4, 1, 0, 0, 0), ex(1, 0, 0, 3), "rs_stall");
      rst_next = 1'b0;
      step(2, mk(1, 2, 0, 1, 0, 4, 1, 0, 0, 0), ex(0, 0, 0, 0), "rst_async");
      step(0, '0, ex(0, 0, 0, 0), "rst_a");
      step(1, '0, ex(0, 0, 0, 0), "rst_b");

      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
